// File: rtl/order_book_dispatcher.sv
// order_book_dispatcher
//   Schedules parsed order commands from NUM_REQ parser lanes onto the four
//   shared per-stock order-book engines over one one-hot-addressed command
//   bus. Commands to different stocks may overlap; commands to the same stock
//   are serialized by a per-stock busy flag. A per-stock watchdog frees a
//   stock whose engine never signals completion.
//
//   Optional feature: define ORDER_BOOK_DISPATCH_STATS_EN to add the
//   saturating stat_issued / stat_timeouts counters and their output ports.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        per-lane handshake (ready is combinational)
//   req_order_id/quantity/price/stock_activate  lane-packed payloads
//   flush / flush_done         drain request / one-cycle drain-complete pulse
//   cmd_*                      registered one-cycle command to the engines
//   eng_done / eng_busy        per-stock completion in / outstanding flag out
//                              (bit 3 = stock 0)
//   err_illegal                pulse: illegal activate dropped
//   timeout_err/timeout_stock  pulse + index of a watchdog expiry
//   stat_issued/stat_timeouts  statistics (feature macro only)
module order_book_dispatcher #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_order_id,
  input  logic [32*NUM_REQ-1:0]   req_quantity,
  input  logic [64*NUM_REQ-1:0]   req_price,
  input  logic [12*NUM_REQ-1:0]   req_stock_activate,
  input  logic                    flush,
  output logic                    cmd_valid,
  output logic [31:0]             cmd_order_id,
  output logic [31:0]             cmd_quantity,
  output logic [63:0]             cmd_price,
  output logic [11:0]             cmd_stock_activate,
  input  logic [3:0]              eng_done,
  output logic [3:0]              eng_busy,
  output logic                    flush_done,
  output logic                    err_illegal,
  output logic                    timeout_err,
  output logic [1:0]              timeout_stock
`ifdef ORDER_BOOK_DISPATCH_STATS_EN
  ,
  output logic [31:0]             stat_issued,
  output logic [15:0]             stat_timeouts
`endif
);

  localparam int         PTR_W    = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t             r_state, w_next;
  logic [PTR_W-1:0]   r_ptr;
  logic [3:0]         r_busy;
  logic [7:0]         r_cnt [4];
  logic               r_cmd_valid, r_err_illegal, r_timeout_err, r_flush_done;
  logic [1:0]         r_timeout_stock;
  logic [31:0]        r_cmd_order_id, r_cmd_quantity;
  logic [63:0]        r_cmd_price;
  logic [11:0]        r_cmd_stock_activate;

  logic               w_grant_en, w_done_enter;
  logic [NUM_REQ-1:0] w_legal, w_elig, w_grant;
  logic [1:0]         w_grp [NUM_REQ];
  logic               w_any_grant, w_issue, w_illegal;
  logic [PTR_W-1:0]   w_sel;
  logic [3:0]         w_set, w_expire, w_release;
  logic [1:0]         w_to_stock;

  // ---------------- FSM: state register / next state / outputs ----------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that skips the assignment would otherwise infer a latch.
    w_next = r_state;
    case (r_state)
      ST_RUN:   if (flush)         w_next = ST_DRAIN;
      ST_DRAIN: if (r_busy == '0)  w_next = ST_DONE;
      ST_DONE:  if (!flush)        w_next = ST_RUN;
      default:                     w_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_grant_en   = (r_state == ST_RUN) && !flush;
    w_done_enter = (r_state == ST_DRAIN) && (r_busy == '0);
  end

  // ---------------- Per-lane decode and eligibility ----------------------
  // Group index g counts 3-bit groups from the LSB, so g is also the
  // eng_busy/eng_done bit of that stock (stock = 3 - g).
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_legal[i] = $onehot(req_stock_activate[12*i +: 12]);
      w_grp[i]   = 2'd0;
      for (int p = 0; p < 12; p++)
        if (req_stock_activate[12*i + p]) w_grp[i] = 2'(p / 3);
      // Illegal commands are always eligible so they are drained, not stuck.
      w_elig[i] = w_grant_en && req_valid[i] && (!w_legal[i] || !r_busy[w_grp[i]]);
    end
  end

  // ---------------- Round-robin arbiter ----------------------------------
  always_comb begin
    int idx;
    idx         = 0;
    w_grant     = '0;
    w_any_grant = 1'b0;
    w_sel       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_any_grant && w_elig[idx]) begin
        w_any_grant  = 1'b1;
        w_grant[idx] = 1'b1;
        w_sel        = PTR_W'(idx);
      end
    end
  end

  assign req_ready = w_grant;
  assign w_issue   = w_any_grant && w_legal[w_sel];
  assign w_illegal = w_any_grant && !w_legal[w_sel];
  assign w_set     = w_issue ? (4'b0001 << w_grp[w_sel]) : 4'b0000;

  // ---------------- Watchdog ---------------------------------------------
  always_comb begin
    w_to_stock = 2'd0;
    for (int g = 0; g < 4; g++) begin
      w_expire[g] = r_busy[g] && !eng_done[g] && (r_cnt[g] == CNT_LAST);
      // Ascending scan: highest g (lowest stock index) wins.
      if (w_expire[g]) w_to_stock = 2'(3 - g);
    end
  end

  // A done and an expiry in the same cycle release the stock as a done.
  assign w_release = r_busy & (eng_done | w_expire);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
      for (int g = 0; g < 4; g++) r_cnt[g] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_busy <= (r_busy & ~w_release) | w_set;
      for (int g = 0; g < 4; g++) begin
        if (w_set[g])                        r_cnt[g] <= '0;
        else if (r_busy[g] && !w_release[g]) r_cnt[g] <= r_cnt[g] + 8'd1;
      end
    end
  end

  // ---------------- Command / status registers --------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr                <= '0;
      r_cmd_valid          <= 1'b0;
      r_cmd_order_id       <= '0;
      r_cmd_quantity       <= '0;
      r_cmd_price          <= '0;
      r_cmd_stock_activate <= '0;
      r_err_illegal        <= 1'b0;
      r_timeout_err        <= 1'b0;
      r_timeout_stock      <= '0;
      r_flush_done         <= 1'b0;
    end else begin
      r_cmd_valid     <= w_issue;
      r_err_illegal   <= w_illegal;
      r_timeout_err   <= |w_expire;
      r_timeout_stock <= w_to_stock;
      r_flush_done    <= w_done_enter;
      if (w_any_grant)
        r_ptr <= (w_sel == PTR_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
      // Payload holds between issues; illegal commands never reach the bus.
      if (w_issue) begin
        r_cmd_order_id       <= req_order_id[32*w_sel +: 32];
        r_cmd_quantity       <= req_quantity[32*w_sel +: 32];
        r_cmd_price          <= req_price[64*w_sel +: 64];
        r_cmd_stock_activate <= req_stock_activate[12*w_sel +: 12];
      end
    end
  end

  assign cmd_valid          = r_cmd_valid;
  assign cmd_order_id       = r_cmd_order_id;
  assign cmd_quantity       = r_cmd_quantity;
  assign cmd_price          = r_cmd_price;
  assign cmd_stock_activate = r_cmd_stock_activate;
  assign eng_busy           = r_busy;
  assign flush_done         = r_flush_done;
  assign err_illegal        = r_err_illegal;
  assign timeout_err        = r_timeout_err;
  assign timeout_stock      = r_timeout_stock;

`ifdef ORDER_BOOK_DISPATCH_STATS_EN
  logic [31:0] r_stat_issued;
  logic [15:0] r_stat_timeouts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_issued   <= '0;
      r_stat_timeouts <= '0;
    end else begin
      if (r_cmd_valid && (r_stat_issued != '1))     r_stat_issued   <= r_stat_issued + 32'd1;
      if (r_timeout_err && (r_stat_timeouts != '1)) r_stat_timeouts <= r_stat_timeouts + 16'd1;
    end
  end

  assign stat_issued   = r_stat_issued;
  assign stat_timeouts = r_stat_timeouts;
`endif

endmodule

// File: tb/tb_order_book_dispatcher.sv
// Testbench for order_book_dispatcher (NUM_REQ=2, TIMEOUT_CYCLES=8).
// Directed stimulus; issued commands, illegal drops, watchdog expiries and
// flush completions are pushed as expectations into queues and a negedge
// monitor pops and compares whenever the DUT pulses the matching output.
module tb_order_book_dispatcher;

  localparam int NUM_REQ = 2;
  localparam int TO      = 8;

  typedef struct {
    logic [11:0] act;
    logic [31:0] id;
  } cmd_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_order_id = '0;
  logic [32*NUM_REQ-1:0] req_quantity = '0;
  logic [64*NUM_REQ-1:0] req_price = '0;
  logic [12*NUM_REQ-1:0] req_stock_activate = '0;
  logic                  flush = 1'b0;
  logic                  cmd_valid;
  logic [31:0]           cmd_order_id, cmd_quantity;
  logic [63:0]           cmd_price;
  logic [11:0]           cmd_stock_activate;
  logic [3:0]            eng_done = '0;
  logic [3:0]            eng_busy;
  logic                  flush_done, err_illegal, timeout_err;
  logic [1:0]            timeout_stock;
`ifdef ORDER_BOOK_DISPATCH_STATS_EN
  logic [31:0]           stat_issued;
  logic [15:0]           stat_timeouts;
`endif

  order_book_dispatcher #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_order_id       (req_order_id),
    .req_quantity       (req_quantity),
    .req_price          (req_price),
    .req_stock_activate (req_stock_activate),
    .flush              (flush),
    .cmd_valid          (cmd_valid),
    .cmd_order_id       (cmd_order_id),
    .cmd_quantity       (cmd_quantity),
    .cmd_price          (cmd_price),
    .cmd_stock_activate (cmd_stock_activate),
    .eng_done           (eng_done),
    .eng_busy           (eng_busy),
    .flush_done         (flush_done),
    .err_illegal        (err_illegal),
    .timeout_err        (timeout_err),
    .timeout_stock      (timeout_stock)
`ifdef ORDER_BOOK_DISPATCH_STATS_EN
    ,
    .stat_issued        (stat_issued),
    .stat_timeouts      (stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  cmd_t       q_cmd [$];
  logic [1:0] q_to  [$];
  bit         q_ill [$];
  bit         q_fd  [$];
  cmd_t       mon_e;
  logic [1:0] mon_s;
  bit         mon_b;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Quantity and price are derived from the order id so the monitor can
  // rebuild the whole expected payload from the queued id.
  task automatic drive(input int lane, input logic [11:0] act, input logic [31:0] id);
    req_valid[lane]                 = 1'b1;
    req_stock_activate[12*lane +: 12] = act;
    req_order_id[32*lane +: 32]     = id;
    req_quantity[32*lane +: 32]     = id + 32'd1000;
    req_price[64*lane +: 64]        = {32'hCAFE0000, id};
  endtask

  task automatic push_cmd(input logic [11:0] act, input logic [31:0] id);
    cmd_t e;
    e.act = act;
    e.id  = id;
    q_cmd.push_back(e);
  endtask

  // ---------------- Monitor ----------------------------------------------
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid) begin
        check("cmd_expected", 128'(q_cmd.size() != 0), 1);
        if (q_cmd.size() != 0) begin
          mon_e = q_cmd.pop_front();
          check("cmd_activate", cmd_stock_activate, mon_e.act);
          check("cmd_order_id", cmd_order_id, mon_e.id);
          check("cmd_quantity", cmd_quantity, mon_e.id + 32'd1000);
          check("cmd_price", cmd_price, {32'hCAFE0000, mon_e.id});
        end
      end
      if (err_illegal) begin
        check("illegal_expected", 128'(q_ill.size() != 0), 1);
        if (q_ill.size() != 0) mon_b = q_ill.pop_front();
      end
      if (timeout_err) begin
        check("timeout_expected", 128'(q_to.size() != 0), 1);
        if (q_to.size() != 0) begin
          mon_s = q_to.pop_front();
          check("timeout_stock", timeout_stock, mon_s);
        end
      end
      if (flush_done) begin
        check("flush_done_expected", 128'(q_fd.size() != 0), 1);
        if (q_fd.size() != 0) mon_b = q_fd.pop_front();
      end
    end
  end

  // ---------------- Stimulus ---------------------------------------------
  initial begin
    // Reset state
    step(); sample();
    check("rst_outputs", {cmd_valid, flush_done, err_illegal, timeout_err, timeout_stock, req_ready}, 0);
    check("rst_busy", eng_busy, 4'b0000);
    step(); reset = 1'b0;

    // T1: single ADD to stock 0, done at cycle 4
    step(); drive(0, 12'h800, 32'h11); sample();
    check("t1_ready_c0", req_ready, 2'b01); push_cmd(12'h800, 32'h11);
    step(); req_valid = '0; sample();
    check("t1_cmd_valid_c1", cmd_valid, 1); check("t1_busy_c1", eng_busy, 4'b1000);
    step(); sample(); check("t1_busy_c2", eng_busy, 4'b1000); check("t1_cmd_pulse", cmd_valid, 0);
    step(); sample(); check("t1_busy_c3", eng_busy, 4'b1000);
    step(); eng_done = 4'b1000; sample(); check("t1_busy_c4", eng_busy, 4'b1000);
    step(); eng_done = 4'b0000; sample(); check("t1_busy_c5", eng_busy, 4'b0000);

    // Reset mid-operation: the in-flight command is lost (pointer is 1 here)
    step(); drive(0, 12'h001, 32'h99); sample(); check("rst_mid_ready", req_ready, 2'b01);
    step(); req_valid = '0; check("rst_mid_cmd_pre", cmd_valid, 1);
    #1 reset = 1'b1;
    #1 check("rst_mid_cmd_clr", cmd_valid, 0); check("rst_mid_busy_clr", eng_busy, 4'b0000);
    step(); reset = 1'b0;

    // T2: round-robin from pointer 0, then alternation
    step(); drive(0, 12'h800, 32'h21); drive(1, 12'h004, 32'h22); sample();
    check("t2_ready_c0", req_ready, 2'b01); push_cmd(12'h800, 32'h21);
    step(); req_valid[0] = 1'b0; sample();
    check("t2_ready_c1", req_ready, 2'b10); check("t2_busy_c1", eng_busy, 4'b1000); push_cmd(12'h004, 32'h22);
    step(); req_valid[1] = 1'b0; drive(0, 12'h100, 32'h23); drive(1, 12'h010, 32'h24); sample();
    check("t2_busy_c2", eng_busy, 4'b1001); check("t2_ready_c2", req_ready, 2'b01); push_cmd(12'h100, 32'h23);
    step(); req_valid[0] = 1'b0; sample();
    check("t2_ready_c3", req_ready, 2'b10); push_cmd(12'h010, 32'h24);
    step(); req_valid[1] = 1'b0; eng_done = 4'b1111; sample(); check("t2_busy_c4", eng_busy, 4'b1111);
    step(); eng_done = 4'b0000; sample(); check("t2_busy_c5", eng_busy, 4'b0000);

    // T3: no head-of-line blocking; lane0 waits for stock 0
    step(); drive(1, 12'h800, 32'h31); sample();
    check("t3_ready_c0", req_ready, 2'b10); push_cmd(12'h800, 32'h31);
    step(); drive(0, 12'h400, 32'h32); drive(1, 12'h020, 32'h33); sample();
    check("t3_ready_c1", req_ready, 2'b10); push_cmd(12'h020, 32'h33);
    step(); req_valid[1] = 1'b0; eng_done = 4'b1000; sample();
    check("t3_ready_c2", req_ready, 2'b00);
    step(); eng_done = 4'b0000; sample();
    check("t3_busy_c3", eng_busy, 4'b0010); check("t3_ready_c3", req_ready, 2'b01); push_cmd(12'h400, 32'h32);
    step(); req_valid[0] = 1'b0; eng_done = 4'b0101; sample(); check("t3_busy_c4", eng_busy, 4'b1010);
    step(); eng_done = 4'b1010; sample(); check("t3_done_nonbusy_ignored", eng_busy, 4'b1010);
    step(); eng_done = 4'b0000; sample(); check("t3_busy_c6", eng_busy, 4'b0000);

    // T4: illegal activates are consumed even when their stock bit is busy
    step(); drive(0, 12'h800, 32'h40); sample(); push_cmd(12'h800, 32'h40);
    step(); req_valid[0] = 1'b0; drive(1, 12'h000, 32'h41); sample();
    check("t4_ready_c0", req_ready, 2'b10); q_ill.push_back(1'b1);
    step(); drive(1, 12'h801, 32'h42); sample();
    check("t4_ready_c1", req_ready, 2'b10); check("t4_err_c1", err_illegal, 1);
    check("t4_busy_c1", eng_busy, 4'b1000); q_ill.push_back(1'b1);
    step(); req_valid[1] = 1'b0; eng_done = 4'b1000; sample();
    check("t4_err_c2", err_illegal, 1); check("t4_no_cmd_c2", cmd_valid, 0); check("t4_busy_c2", eng_busy, 4'b1000);
    step(); eng_done = 4'b0000; sample();
    check("t4_err_c3", err_illegal, 0); check("t4_busy_c3", eng_busy, 4'b0000);

    // T5: watchdog on stock 1 fires at grant+9
    step(); drive(0, 12'h100, 32'h51); sample(); push_cmd(12'h100, 32'h51); q_to.push_back(2'd1);
    step(); req_valid[0] = 1'b0; sample(); check("t5_busy_c1", eng_busy, 4'b0100);
    for (int c = 2; c <= 8; c++) begin
      step(); sample();
      check("t5_busy_hold", eng_busy, 4'b0100);
      check("t5_no_err", timeout_err, 0);
    end
    step(); sample();
    check("t5_err_c9", timeout_err, 1); check("t5_stock_c9", timeout_stock, 2'd1);
    check("t5_busy_c9", eng_busy, 4'b0000);
    step(); sample(); check("t5_err_c10", timeout_err, 0);

    // T5b: done on the expiry cycle wins, no error
    step(); drive(0, 12'h100, 32'h52); sample(); push_cmd(12'h100, 32'h52);
    step(); req_valid[0] = 1'b0;
    for (int c = 2; c <= 7; c++) step();
    step(); eng_done = 4'b0100; sample(); check("t5b_busy_c8", eng_busy, 4'b0100);
    step(); eng_done = 4'b0000; sample();
    check("t5b_busy_c9", eng_busy, 4'b0000); check("t5b_no_err_c9", timeout_err, 0);
    step(); sample(); check("t5b_no_err_c10", timeout_err, 0);

    // T6: flush with two stocks busy
    step(); drive(0, 12'h800, 32'h61); drive(1, 12'h004, 32'h62); sample();
    check("t6_ready_c0", req_ready, 2'b10); push_cmd(12'h004, 32'h62);
    step(); req_valid[1] = 1'b0; sample();
    check("t6_ready_c1", req_ready, 2'b01); push_cmd(12'h800, 32'h61);
    step(); drive(0, 12'h100, 32'h63); flush = 1'b1; sample();
    check("t6_ready_flush_c2", req_ready, 2'b00); check("t6_busy_c2", eng_busy, 4'b1001);
    step(); eng_done = 4'b0001; sample();
    check("t6_ready_c3", req_ready, 2'b00); check("t6_fd_c3", flush_done, 0);
    step(); eng_done = 4'b1000; sample(); check("t6_busy_c4", eng_busy, 4'b1000);
    step(); eng_done = 4'b0000; sample();
    check("t6_busy_c5", eng_busy, 4'b0000); check("t6_fd_c5", flush_done, 0); q_fd.push_back(1'b1);
    step(); sample(); check("t6_fd_c6", flush_done, 1); check("t6_ready_c6", req_ready, 2'b00);
    step(); sample(); check("t6_fd_c7", flush_done, 0); check("t6_ready_c7", req_ready, 2'b00);
    step(); flush = 1'b0; sample(); check("t6_ready_c8", req_ready, 2'b00);
    step(); sample(); check("t6_ready_resume", req_ready, 2'b01); push_cmd(12'h100, 32'h63);
    step(); req_valid[0] = 1'b0; eng_done = 4'b0100; sample(); check("t6_busy_c10", eng_busy, 4'b0100);
    step(); eng_done = 4'b0000; sample(); check("t6_busy_c11", eng_busy, 4'b0000);

    step(); step(); sample();
    check("q_cmd_drained", q_cmd.size(), 0);
    check("q_illegal_drained", q_ill.size(), 0);
    check("q_timeout_drained", q_to.size(), 0);
    check("q_flush_drained", q_fd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/order_book_dispatcher.md
Name: order_book_dispatcher

Overview:
- Schedules parsed order commands from NUM_REQ parser lanes onto the four shared per-stock order-book engines.
- Commands for different stocks may be in flight at the same time; commands for the same stock are serialized.
- A per-engine watchdog frees a stock if its engine never completes.
- The block sits between the parser lanes and the stock engines and drives one shared, one-hot-addressed command bus.

Parameters:
- NUM_REQ, 2: number of requesting parser lanes (2..4).
- TIMEOUT_CYCLES, 255: busy cycles without eng_done before the watchdog fires (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-lane command valid.
- req_ready  out  NUM_REQ  per-lane accept. Combinational; a transfer occurs when valid&ready.
- req_order_id  in  32*NUM_REQ  lane i occupies bits [32i+31:32i].
- req_quantity  in  32*NUM_REQ  packed the same way.
- req_price  in  64*NUM_REQ  packed the same way.
- req_stock_activate  in  12*NUM_REQ  one-hot. Stock k uses bits [11-3k : 9-3k] as {ADD, DELETE, DECREASE}.
- flush  in  1  level request: stop granting and drain.
- cmd_valid  out  1  one-cycle command pulse to the engines.
- cmd_order_id  out  32  registered payload.
- cmd_quantity  out  32  registered payload.
- cmd_price  out  64  registered payload.
- cmd_stock_activate  out  12  registered one-hot target and operation.
- eng_done  in  4  per-stock completion pulse; bit 3 = stock 0.
- eng_busy  out  4  per-stock outstanding flag.
- flush_done  out  1  one-cycle pulse when the drain is complete.
- err_illegal  out  1  one-cycle pulse: a command with an illegal activate was dropped.
- timeout_err  out  1  one-cycle pulse: a watchdog fired.
- timeout_stock  out  2  index of the timed-out stock; valid while timeout_err is high.

Behaviour:
- Reset values: all outputs 0, FSM in RUN, round-robin pointer 0, all watchdog counters 0.
- Target decode:
  - stock = index of the 3-bit group containing the single set bit.
  - An activate is legal only if exactly one of the 12 bits is set.
- Eligibility of lane i in RUN: req_valid[i] is high, and either the activate is illegal or eng_busy[stock] is 0.
- Arbitration:
  - Round-robin starting at the pointer.
  - At most one req_ready bit is high per cycle.
  - On a grant, the pointer moves to (granted+1) mod NUM_REQ.
  - Blocked lanes do not stall eligible lanes; there is no head-of-line blocking across lanes.
- Legal grant at edge N:
  - At N+1, cmd_valid=1 and the payload is registered.
  - eng_busy[stock] is set at the same edge.
  - Latency from accept to cmd_valid is 1 cycle. The payload holds until the next grant.
- Illegal grant: the command is consumed without being issued; err_illegal=1 at N+1; eng_busy is unchanged.
- Busy release: eng_busy[k] clears on the edge after eng_done[k]=1.
  - eng_done to a non-busy stock is ignored.
  - A new grant to stock k is possible at the earliest one cycle after the clear (busy is sampled pre-clear).
- Watchdog:
  - cnt[k] resets to 0 when busy is set and increments each cycle busy is held.
  - When cnt[k]==TIMEOUT_CYCLES-1 and eng_done[k]=0: clear busy, pulse timeout_err, set timeout_stock=k.
  - If eng_done and expiry occur in the same cycle, done wins and no error is raised.
  - Timeouts on two stocks cannot coincide, because issues are at least 1 cycle apart. Lowest index wins regardless.
- FSM (RUN, DRAIN, DONE):
  - RUN: granting. flush=1 moves to DRAIN; no grant is made in that cycle.
  - DRAIN: req_ready=0. When eng_busy==0, go to DONE.
  - DONE: pulse flush_done for 1 cycle, then go to RUN if flush=0; otherwise stay in DONE with no further pulses.
- Reset mid-operation: asynchronous clear. The in-flight cmd_valid is lost and busy flags are cleared; engines are reset by the same signal.

Optional Feature:
- Macro: ORDER_BOOK_DISPATCH_STATS_EN.
- Defined: adds outputs stat_issued (32 bits) and stat_timeouts (16 bits).
  - stat_issued increments on each cmd_valid.
  - stat_timeouts increments on each timeout_err.
  - Both saturate, and both are cleared by reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Lane0 ADD stock0 (activate 12'h800, id 32'h11), eng_done at cycle 4 -> ready0 high at cycle 0, cmd_valid at 1 with 12'h800/id 32'h11, eng_busy=4'b1000 from 1, clears at 5.
- Lane0 12'h800 and lane1 12'h004 both valid, pointer 0 -> lane0 granted at cycle 0, lane1 at cycle 1, eng_busy=4'b1001. Then two new requests -> grants alternate.
- Stock0 busy, lane0 requests stock0, lane1 requests stock2 (12'h020) -> lane1 granted immediately; lane0 waits until one cycle after eng_done[3].
- Lane1 activate 12'h000, then 12'h801 -> each consumed, err_illegal pulses, no cmd_valid, eng_busy unchanged.
- TIMEOUT_CYCLES=8, issue to stock1 with no done -> timeout_err=1, timeout_stock=1 at issue+9, eng_busy[2] cleared. Repeat with eng_done on the expiry cycle -> no error.
- Two stocks busy, assert flush -> req_ready=0 while draining; flush_done pulses once, the cycle after the last busy clears; with flush low, RUN resumes.
